gui_kbd_matrix: RTL

- Keyboard responder between the simulation GUI host and the Orion-PRO core keyboard port.
- The GUI pushes key press/release events over a valid/ready handshake. The block keeps the 8x8 key matrix plus modifier state and answers the core's row scans with active-low column data.
- A hold timer keeps every state change stable for a minimum time, so the core's software scan loop cannot miss it.

---
 rtl/gui_kbd_pkg.sv | 23 ++
 rtl/gui_kbd_fifo.sv | 53 +++++
 rtl/gui_kbd_matrix.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gui_kbd_pkg.sv
// Shared types and key-code constants for the GUI keyboard responder.
package gui_kbd_pkg;

  // Special key codes above the 8x8 matrix range.
  localparam logic [6:0] KEY_SHIFT  = 7'd64;
  localparam logic [6:0] KEY_CTRL   = 7'd65;
  localparam logic [6:0] KEY_RUSLAT = 7'd66;
  localparam logic [6:0] KEY_MAX    = 7'd66;

  // One GUI key event as stored in the FIFO.
  typedef struct packed {
    logic [6:0] code;
    logic       press;
  } kbd_event_t;

  // Apply sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } kbd_state_t;

endpackage

// File: rtl/gui_kbd_fifo.sv
// Small synchronous FIFO of key events with flush; pointers carry one
// extra wrap bit so full and empty are told apart by the MSB.
module gui_kbd_fifo
  import gui_kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_push,
  input  kbd_event_t i_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output kbd_event_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  kbd_event_t  r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Event storage; contents need no reset since empty gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/gui_kbd_matrix.sv
// Keyboard responder: queues GUI key events, applies them one at a time
// with a minimum hold between changes, and answers active-low row scans.
module gui_kbd_matrix
  import gui_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 20000,
  parameter int HOLD_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_key_valid,
  output logic       o_key_ready,
  input  logic [6:0] i_key_code,
  input  logic       i_key_press,
  input  logic       i_clear_all,
  input  logic [7:0] i_row_sel,
  output logic [7:0] o_col,
  output logic [2:0] o_mod_n,
  output logic       o_busy
);

  kbd_state_t        r_state;
  kbd_state_t        w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  kbd_event_t        r_evt;
  kbd_event_t        w_fifo_data;
  kbd_event_t        w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_apply;
  logic              w_evt_valid;
  logic [63:0]       r_matrix;
  logic [2:0]        r_mod;
  logic [7:0]        r_col;
  logic [2:0]        r_mod_n;

  // Column c is pulled low when any driven-low row has key (row, c) pressed.
  function automatic logic [7:0] scan_cols(input logic [7:0] row_sel_n,
                                           input logic [63:0] m);
    logic [7:0] acc;
    acc = '0;
    for (int r = 0; r < 8; r++) begin
      if (!row_sel_n[r]) acc = acc | m[r*8 +: 8];
    end
    return ~acc;
  endfunction

  assign o_key_ready = !w_full;
  assign w_push      = i_key_valid && !w_full && !i_clear_all;
  assign w_push_data = '{code: i_key_code, press: i_key_press};
  assign w_evt_valid = (r_evt.code <= KEY_MAX);
  assign o_busy      = !w_empty || (r_state != ST_IDLE);
  assign o_col       = r_col;
  assign o_mod_n     = r_mod_n;

  gui_kbd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_push   (w_push),
    .i_data   (w_push_data),
    .i_pop    (w_pop),
    .i_flush  (i_clear_all),
    .o_data   (w_fifo_data),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and apply strobe; clear-all forces IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = w_evt_valid ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (r_hold == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_clear_all) begin
      w_state_nxt = ST_IDLE;
      w_pop       = 1'b0;
      w_apply     = 1'b0;
    end
  end

  // Capture the event being popped for the APPLY cycle.
  always_ff @(posedge i_clk) begin
    if (w_pop) r_evt <= w_fifo_data;
  end

  // Hold counter: loaded on a real change, counts down to zero in HOLD.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hold <= '0;
    end else if (i_clear_all) begin
      r_hold <= '0;
    end else if (w_apply && w_evt_valid) begin
      r_hold <= HOLD_W'(HOLD_CYCLES - 1);
    end else if ((r_state == ST_HOLD) && (r_hold != '0)) begin
      r_hold <= r_hold - HOLD_W'(1);
    end
  end

  // Key matrix and modifier state; codes above KEY_MAX are a no-op.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_matrix <= '0;
      r_mod    <= '0;
    end else if (i_clear_all) begin
      r_matrix <= '0;
      r_mod    <= '0;
    end else if (w_apply) begin
      if (!r_evt.code[6])   r_matrix[r_evt.code[5:0]] <= r_evt.press;
      else if (w_evt_valid) r_mod[r_evt.code[1:0]]    <= r_evt.press;
    end
  end

  // Registered scan response and modifier outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col   <= 8'hFF;
      r_mod_n <= 3'b111;
    end else if (i_clear_all) begin
      r_col   <= 8'hFF;
      r_mod_n <= 3'b111;
    end else begin
      r_col   <= scan_cols(i_row_sel, r_matrix);
      r_mod_n <= ~r_mod;
    end
  end

endmodule
